// File: rtl/simon_pkg.sv
// Colour codes shared by the Simon key converter, game controller and LED player.
package simon_pkg;

    typedef logic [1:0] color_t;

    localparam color_t B = 2'b00;
    localparam color_t G = 2'b01;
    localparam color_t R = 2'b10;
    localparam color_t Y = 2'b11;

    function automatic logic [3:0] color_to_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Clear/enable up-counter with a terminal-count compare against a runtime value.
module cycle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == last);

endmodule

// File: rtl/color_led_player.sv
// Plays one Simon colour per handshake: LED lit for ON_CYCLES, dark for GAP_CYCLES, then done.
module color_led_player
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [1:0] in_color,
    output logic       in_ready,
    output logic [3:0] leds,
    output logic       busy,
    output logic       done
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    color_t        color_q, color_d;
    logic          done_q, done_d;
    logic          tmr_clr, tmr_en, tmr_tc;
    logic [CW-1:0] tmr_last;

    assign in_ready = (state_q == S_IDLE) & ~reset & ~abort;

    // One timer serves both phases; its compare value follows the state.
    assign tmr_last = (state_q == S_GAP) ? GAP_LAST : ON_LAST;

    always_comb begin
        state_d = state_q;
        color_d = color_q;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        color_d = in_color;
                        state_d = S_ON;
                        tmr_clr = 1'b1;
                    end
                end
                S_ON: begin
                    if (tmr_tc) begin
                        state_d = S_GAP;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr_tc) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tmr_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            color_q <= B;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            done_q  <= done_d;
        end
    end

    cycle_timer #(
        .W(CW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .last (tmr_last),
        .tc   (tmr_tc)
    );

    // Outputs decode registered state only, so they cannot glitch.
    assign leds = (state_q == S_ON) ? color_to_onehot(color_q) : 4'b0000;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_color_led_player.sv
// Randomised and directed bench for color_led_player against a cycle-age reference model.
module tb_color_led_player;

    localparam int ON  = 3;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       abort;
    logic       in_valid;
    logic [1:0] in_color;
    logic       in_ready;
    logic [3:0] leds;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    color_led_player #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .abort   (abort),
        .in_valid(in_valid),
        .in_color(in_color),
        .in_ready(in_ready),
        .leds    (leds),
        .busy    (busy),
        .done    (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: a token is "active" for ON+GAP cycles after its accept cycle.
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    int         m_age    = 0;
    logic [1:0] m_color  = 2'b00;
    int         done_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_leds();
        if (reset) return 4'b0000;
        if (m_active && m_age >= 1 && m_age <= ON) return 4'b0001 << m_color;
        return 4'b0000;
    endfunction

    function automatic logic exp_ready();
        return !m_active && !reset && !abort;
    endfunction

    // Check all outputs mid-cycle, advance the model, then step to just after the next edge.
    task automatic cycle();
        logic rdy;
        @(negedge clk);
        rdy = exp_ready();
        check_eq("leds",     32'(leds),     32'(exp_leds()));
        check_eq("busy",     32'(busy),     32'(m_active && !reset));
        check_eq("done",     32'(done),     32'(m_done && !reset));
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        if (done === 1'b1) done_cnt++;
        if (reset || abort) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (m_active) begin
            if (m_age == ON + GAP) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else begin
                m_age++;
                m_done = 1'b0;
            end
        end else if (in_valid && rdy) begin
            m_active = 1'b1;
            m_age    = 1;
            m_color  = in_color;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_color = 2'b00;
        @(posedge clk);
        #1;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // Single colour R
        in_valid = 1'b1;
        in_color = 2'b10;
        cycle();
        in_valid = 1'b0;
        repeat (7) cycle();

        // Back-to-back B, G, Y with valid held
        done_cnt = 0;
        in_valid = 1'b1;
        in_color = 2'b00;
        repeat (6) cycle();
        in_color = 2'b01;
        repeat (6) cycle();
        in_color = 2'b11;
        repeat (6) cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        check_eq("b2b_done_count", 32'(done_cnt), 32'd3);

        // Input toggling while busy
        in_valid = 1'b1;
        in_color = 2'b11;
        cycle();
        repeat (5) begin
            in_color = 2'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // Abort during ON, then abort racing a valid in IDLE
        done_cnt = 0;
        in_valid = 1'b1;
        in_color = 2'b01;
        cycle();
        in_valid = 1'b0;
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();
        abort    = 1'b1;
        in_valid = 1'b1;
        cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        repeat (6) cycle();
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);

        // Reset asserted mid-cycle during GAP
        in_valid = 1'b1;
        in_color = 2'b10;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_leds",  32'(leds),     32'd0);
        check_eq("rst_async_busy",  32'(busy),     32'd0);
        check_eq("rst_async_done",  32'(done),     32'd0);
        check_eq("rst_async_ready", 32'(in_ready), 32'd0);
        repeat (2) cycle();
        reset    = 1'b0;
        done_cnt = 0;
        repeat (4) cycle();
        check_eq("rst_no_done", 32'(done_cnt), 32'd0);
        in_valid = 1'b1;
        in_color = 2'b00;
        cycle();
        in_valid = 1'b0;
        repeat (7) cycle();

        // Random traffic
        repeat (400) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_color = 2'($urandom);
            abort    = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        repeat (8) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/color_led_player.md
# color_led_player

Timed playback driver for the Simon colour sequence. It accepts 2-bit colour codes (B/G/R/Y) over a valid/ready handshake and drives the matching one-hot LED for a fixed on-time, followed by a dark gap. It then signals completion and accepts the next code. It sits between the game controller's sequence memory and the board LEDs, and performs the inverse of the keys-to-colour conversion on the player-input side.

## Interface
- `ON_CYCLES`, default 25_000_000: clock cycles the LED stays lit per colour; must be ≥1.
- `GAP_CYCLES`, default 12_500_000: clock cycles all LEDs stay dark after each colour; must be ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `abort`  in  1  synchronous cancel of the current playback.
- `in_valid`  in  1  a colour code is offered.
- `in_color`  in  2  colour code: B=00, G=01, R=10, Y=11.
- `in_ready`  out  1  the block will accept `in_color` at this edge.
- `leds`  out  4  one-hot LED drive: B→0001, G→0010, R→0100, Y→1000; 0000 when dark.
- `busy`  out  1  high while in ON or GAP.
- `done`  out  1  one-cycle pulse when a colour's gap completes.

## Operation
- The FSM has three states: IDLE, ON and GAP.
- **IDLE**
  - `in_ready = ~reset & ~abort`.
  - When `in_valid & in_ready` at an edge: latch `in_color`, clear the counter and go to ON.
- **ON**
  - `leds = onehot(latched colour)`.
  - The counter increments each cycle. When it reaches `ON_CYCLES-1`, clear it and go to GAP.
- **GAP**
  - `leds = 0000`.
  - When the counter reaches `GAP_CYCLES-1`, go to IDLE and set `done` for the next cycle.
- Counter width is `$clog2(max(ON_CYCLES, GAP_CYCLES))`, with a minimum of 1. It never wraps, because it is cleared on every state exit.
- Outside IDLE:
  - `in_ready` is 0.
  - `in_valid` and `in_color` are ignored.
  - Changes on `in_color` never affect the lit LED.
- `abort`, from any state:
  - Next state is IDLE, with `leds=0000`, `busy=0` and no `done`.
  - If `abort` and `in_valid` are both high in IDLE, `abort` wins and nothing is accepted.
- `reset`, asynchronous:
  - Outputs go immediately to `leds=0000`, `busy=0`, `done=0`, `in_ready=0`; state goes to IDLE.
  - A token in flight is lost.
  - `in_ready` rises in the first cycle after deassertion.

## Timing
- The accepting edge is at cycle T.
- LEDs lit during cycles T+1 … T+ON_CYCLES.
- Dark during the next `GAP_CYCLES` cycles.
- `done=1` and `in_ready=1` in cycle T+ON_CYCLES+GAP_CYCLES+1.
- Peak throughput is one colour per `ON_CYCLES+GAP_CYCLES+1` cycles. This is achieved with `in_valid` held high, and the next code is accepted on the `done` cycle.
- `leds`, `busy` and `done` are registered, or decoded from registered state only, so they are glitch-free.
- `in_ready` is combinational from state, `abort` and `reset`.

## Structure
- Shared package `simon_pkg`, also used by the key converter and the game controller, holds:
  - `color_t` (2-bit);
  - localparams `B`, `G`, `R`, `Y`;
  - a function `color_to_onehot`.
- The FSM state enum stays local to this module.
- One sub-module is natural: `cycle_timer`, a clear/enable up-counter with a terminal-count compare. It is instantiated once and reused for both ON and GAP, with the compare value muxed by state.

## Test plan
All scenarios use `ON_CYCLES=3`, `GAP_CYCLES=2`.
- **Reset:** assert `reset` mid-cycle → `leds=0000`, `busy=0`, `done=0`, `in_ready=0` immediately; `in_ready=1` the first cycle after release.
- **Single colour:** R (10) accepted at T → `leds=0100` in T+1..T+3; `0000` in T+4..T+5; `done=1`, `busy=0` and `in_ready=1` at T+6; `done=0` at T+7.
- **Back-to-back:** `in_valid` held with B, G, Y presented in turn → `leds` 0001, then 0010, then 1000, each lit for 3 cycles, with a 6-cycle period and exactly three `done` pulses.
- **Input changes while busy:** `in_color` toggles every cycle during ON/GAP with `in_valid=1` → lit pattern unchanged; `in_ready=0` throughout.
- **Abort during ON:** `abort` at T+2 → `leds=0000` and `busy=0` at T+3, no `done`, `in_ready=1` at T+3. Abort with `in_valid` in IDLE → no accept.
- **Reset during GAP:** `reset` at T+4 → outputs cleared asynchronously. After release the block is in IDLE, `done` is never pulsed, and the next accepted code plays normally.
